// File: rtl/pio_poll_pkg.sv
// Shared definitions for the PIO poll controller: register map, bit positions, FSM states.
package pio_poll_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_DIVISOR = 2'd3;

  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_COUNT_LSB = 4;
  localparam int unsigned STATUS_OVF_BIT   = 8;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;

  localparam logic [1:0] PIO_SAMPLE_ADDR = 2'd0;
  localparam logic [1:0] PIO_IDLE_ADDR   = 2'd1;

  typedef enum logic [1:0] {IDLE, WAIT, ADDR, CAPTURE} poll_state_e;

endpackage

// File: rtl/pio_poll_fifo.sv
// First-word-fall-through change FIFO; head reads 0 while empty.
module pio_poll_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/pio_poll_ctrl.sv
// Autonomous PIO poll scheduler: samples the PIO at a programmable interval and queues
// changed values for the CPU, with a level interrupt while data is pending.
module pio_poll_ctrl
  import pio_poll_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DIV_RST    = 50000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [1:0]        pio_address,
  input  logic [DATA_W-1:0] pio_readdata,
  input  logic [1:0]        s_address,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [31:0]       s_writedata,
  output logic [31:0]       s_readdata,
  output logic              irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  poll_state_e       state_q, state_d;
  logic [DIV_W-1:0]  timer_q, timer_d, divisor_q, reload;
  logic              enable_q, irq_en_q, ovf_q, last_valid_q, irq_q;
  logic [DATA_W-1:0] last_q, fifo_head;
  logic [31:0]       s_readdata_q, rdata;
  logic              push, pop, drop, ovf_clr, fifo_full, fifo_empty, unused_wdata;
  logic [CW-1:0]     fifo_count;

  assign reload       = (divisor_q == '0) ? '0 : divisor_q - DIV_W'(1);
  assign pio_address  = (state_q == ADDR) ? PIO_SAMPLE_ADDR : PIO_IDLE_ADDR;
  assign pop          = s_read && (s_address == REG_DATA);
  assign drop         = push && fifo_full && !pop;
  assign ovf_clr      = s_write && (s_address == REG_STATUS) && s_writedata[STATUS_OVF_BIT];
  assign s_readdata   = s_readdata_q;
  assign irq          = irq_q;
  assign unused_wdata = ^s_writedata;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_q) begin
          state_d = WAIT;
          timer_d = reload;
        end
      end
      WAIT: begin
        if (timer_q == '0) state_d = ADDR;
        else               timer_d = timer_q - DIV_W'(1);
      end
      ADDR: state_d = CAPTURE;
      CAPTURE: begin
        push    = !last_valid_q || (pio_readdata != last_q);
        state_d = WAIT;
        timer_d = reload;
      end
    endcase
    // Disable wins from any state and drops a sample that is in flight.
    if (!enable_q) begin
      state_d = IDLE;
      push    = 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (s_address)
      REG_DATA:    rdata = 32'(fifo_head);
      REG_STATUS: begin
        rdata[STATUS_OVF_BIT]                = ovf_q;
        rdata[STATUS_COUNT_LSB +: CW]        = fifo_count;
        rdata[STATUS_FULL_BIT]               = fifo_full;
        rdata[STATUS_EMPTY_BIT]              = fifo_empty;
      end
      REG_CONTROL: begin
        rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
        rdata[CTRL_ENABLE_BIT] = enable_q;
      end
      REG_DIVISOR: rdata = 32'(divisor_q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      enable_q     <= 1'b0;
      irq_en_q     <= 1'b0;
      divisor_q    <= DIV_W'(DIV_RST);
      ovf_q        <= 1'b0;
      last_valid_q <= 1'b0;
      last_q       <= '0;
      s_readdata_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (state_q == CAPTURE && enable_q) begin
        last_q       <= pio_readdata;
        last_valid_q <= 1'b1;
      end
      if (s_write && s_address == REG_CONTROL) begin
        enable_q <= s_writedata[CTRL_ENABLE_BIT];
        irq_en_q <= s_writedata[CTRL_IRQ_EN_BIT];
      end
      if (s_write && s_address == REG_DIVISOR) divisor_q <= s_writedata[DIV_W-1:0];
      // A dropped push in the same cycle as a clear leaves the flag set.
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
      if (s_read) s_readdata_q <= rdata;
      irq_q <= irq_en_q && !fifo_empty;
    end
  end

  pio_poll_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (pio_readdata),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_pio_poll_ctrl.sv
// Directed bench for pio_poll_ctrl with a behavioural PIO (registered read, 0 off address 0).
module tb_pio_poll_ctrl;
  import pio_poll_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pio_address;
  logic [31:0] pio_readdata = '0;
  logic [31:0] in_port = '0;
  logic [1:0]  s_address = '0;
  logic        s_read = 1'b0, s_write = 1'b0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) pio_readdata <= (pio_address == 2'd0) ? in_port : 32'd0;

  pio_poll_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .pio_address  (pio_address),
    .pio_readdata (pio_readdata),
    .s_address    (s_address),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .irq          (irq)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    s_address = addr;
    s_read    = 1'b1;
    cyc();
    s_read = 1'b0;
    data   = s_readdata;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    s_address   = addr;
    s_writedata = data;
    s_write     = 1'b1;
    cyc();
    s_write = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check(tag, d, exp);
  endtask

  task automatic wait_addr(input int budget);
    int n = 0;
    while (pio_address !== 2'd0 && n < budget) begin
      cyc();
      n++;
    end
    check("wait_addr_timeout", {30'd0, pio_address}, 32'd0);
  endtask

  // Cycles from one ADDR cycle to the next; caller is positioned in an ADDR cycle.
  task automatic measure_period(input string tag, input int exp);
    int n = 1;
    cyc();
    check({tag, "_addr_width"}, {30'd0, pio_address}, 32'd1);
    while (pio_address !== 2'd0 && n < 20) begin
      cyc();
      n++;
    end
    check(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] vals[6];
    logic [31:0] d;
    int zeros;

    vals = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
             32'h4444_4444, 32'h5555_5555, 32'h6666_6666};

    // Reset values
    cyc(); cyc();
    reset = 1'b0;
    check("rst_pio_addr", {30'd0, pio_address}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    read_check("rst_data", REG_DATA, 32'd0);
    read_check("rst_status", REG_STATUS, 32'h1);
    read_check("rst_control", REG_CONTROL, 32'd0);
    read_check("rst_divisor", REG_DIVISOR, 32'd50000);

    // Divisor 3: period 5, single-cycle ADDR, first sample pushed
    in_port = 32'hA5;
    bus_write(REG_DIVISOR, 32'd3);
    bus_write(REG_CONTROL, 32'h3);
    wait_addr(30);
    measure_period("period_div3", 5);
    check("irq_after_push", {31'd0, irq}, 32'd1);
    read_check("data_a5", REG_DATA, 32'hA5);
    read_check("status_after_pop", REG_STATUS, 32'h1);
    check("irq_dropped", {31'd0, irq}, 32'd0);

    // Constant input over 10 polls: one entry
    in_port = 32'h12;
    repeat (50) cyc();
    read_check("status_one_entry", REG_STATUS, 32'h10);
    read_check("data_12", REG_DATA, 32'h12);
    read_check("status_empty_again", REG_STATUS, 32'h1);

    // Six distinct values with no reads: overflow
    for (int i = 0; i < 6; i++) begin
      in_port = vals[i];
      repeat (5) cyc();
    end
    repeat (3) cyc();
    read_check("status_overflow", REG_STATUS, 32'h142);
    check("irq_full", {31'd0, irq}, 32'd1);
    for (int i = 0; i < 4; i++) read_check($sformatf("ovf_pop%0d", i), REG_DATA, vals[i]);
    read_check("status_drained_ovf", REG_STATUS, 32'h101);
    bus_write(REG_STATUS, 32'h100);
    read_check("status_ovf_cleared", REG_STATUS, 32'h1);

    // Fill to full, then pop in the same cycle as a capture
    for (int i = 0; i < 4; i++) begin
      in_port = 32'h7777_7777 + 32'(i) * 32'h1111_1111;
      repeat (5) cyc();
    end
    repeat (3) cyc();
    read_check("status_full", REG_STATUS, 32'h42);
    wait_addr(10);
    in_port = 32'hBB;
    cyc();
    read_check("pop_during_capture", REG_DATA, 32'h7777_7777);
    read_check("status_still_full", REG_STATUS, 32'h42);
    read_check("drain0", REG_DATA, 32'h8888_8888);
    read_check("drain1", REG_DATA, 32'h9999_9999);
    read_check("drain2", REG_DATA, 32'hAAAA_AAAA);
    read_check("drain_last_new", REG_DATA, 32'hBB);
    read_check("status_drained", REG_STATUS, 32'h1);

    // Disable during ADDR: sample discarded, FSM stops
    wait_addr(10);
    in_port = 32'hCC;
    bus_write(REG_CONTROL, 32'h0);
    zeros = 0;
    for (int i = 0; i < 10; i++) begin
      if (pio_address === 2'd0) zeros++;
      cyc();
    end
    check("disabled_no_addr", 32'(zeros), 32'd0);
    read_check("status_no_push", REG_STATUS, 32'h1);

    // Divisor 0 acts as 1: period 3; last value kept across disable so CC is pushed
    bus_write(REG_DIVISOR, 32'd0);
    bus_write(REG_CONTROL, 32'h1);
    wait_addr(20);
    measure_period("period_div0", 3);
    read_check("status_cc_pushed", REG_STATUS, 32'h10);
    check("irq_masked", {31'd0, irq}, 32'd0);

    // Reset during WAIT
    wait_addr(10);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("midrst_pio_addr", {30'd0, pio_address}, 32'd1);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_readdata", s_readdata, 32'd0);
    read_check("midrst_status", REG_STATUS, 32'h1);
    read_check("midrst_control", REG_CONTROL, 32'd0);
    read_check("midrst_divisor", REG_DIVISOR, 32'd50000);
    bus_read(REG_DATA, d);
    check("midrst_data", d, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
